muxn_skid: RTL

- Parametrised N-input, WIDTH-bit select stage with valid/ready handshakes on both sides.
- Selected word is registered into a 2-entry skid buffer (main + skid), so throughput is full and ready paths are registered.
- Successor to the fixed 64-bit 3:1 forwarding/writeback mux. Adds generic width and input count, pipelining, backpressure and illegal-select reporting.
- Used on datapath select points that are being retimed.

---
 rtl/muxn_skid.sv | 113 +++++++++++
 1 files changed

// File: rtl/muxn_skid.sv
// N-input WIDTH-bit select stage feeding a 2-entry skid buffer with valid/ready on both sides.
// Optional illegal-select counter port err_cnt enabled by defining MUXN_SKID_ERR_CNT_EN.
module muxn_skid #(
   parameter int                 WIDTH       = 64,
   parameter int                 NUM_IN      = 3,
   parameter int                 SEL_W       = $clog2(NUM_IN),
   parameter logic [WIDTH-1:0]   DEFAULT_VAL = {WIDTH{1'b0}}
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]        in_sel,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_illegal,
   output logic                    err_sticky,
`ifdef MUXN_SKID_ERR_CNT_EN
   output logic [7:0]              err_cnt,
`endif
   input  logic                    err_clr
);

   logic [WIDTH-1:0] sel_word;
   logic             sel_ill;

   logic             main_valid, skid_valid;
   logic [WIDTH-1:0] main_data,  skid_data;
   logic             main_ill,   skid_ill;

   logic             accept, emit;
   logic             ill_accept;

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sel_word = DEFAULT_VAL;
      sel_ill  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (in_sel == SEL_W'(k)) begin
            sel_word = in_data[k*WIDTH +: WIDTH];
            sel_ill  = 1'b0;
         end
      end
   end

   // in_ready comes straight off the skid valid flop, so it never sees out_ready combinationally.
   assign in_ready    = ~skid_valid;
   assign accept      = in_valid & in_ready;
   assign emit        = main_valid & out_ready;
   assign ill_accept  = accept & sel_ill;

   assign out_valid   = main_valid;
   assign out_data    = main_data;
   assign out_illegal = main_ill;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_ill   <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_ill   <= 1'b0;
      end else begin
         if (!main_valid) begin
            if (accept) begin
               main_valid <= 1'b1;
               main_data  <= sel_word;
               main_ill   <= sel_ill;
            end
         end else if (!skid_valid) begin
            if (accept && emit) begin
               main_data  <= sel_word;
               main_ill   <= sel_ill;
            end else if (accept) begin
               skid_valid <= 1'b1;
               skid_data  <= sel_word;
               skid_ill   <= sel_ill;
            end else if (emit) begin
               main_valid <= 1'b0;
            end
         end else if (emit) begin
            main_data  <= skid_data;
            main_ill   <= skid_ill;
            skid_valid <= 1'b0;
         end
      end
   end

   // Set has priority over clear when both land in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)             err_sticky <= 1'b0;
      else if (ill_accept) err_sticky <= 1'b1;
      else if (err_clr)    err_sticky <= 1'b0;
   end

`ifdef MUXN_SKID_ERR_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 8'd0;
      end else if (ill_accept) begin
         if (err_clr)                err_cnt <= 8'd1;
         else if (err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
      end else if (err_clr) begin
         err_cnt <= 8'd0;
      end
   end
`endif

endmodule
